// File: rtl/pc_fetch_unit_if.sv
// Decoder/LUT-to-fetch-unit bundle: control strobes and branch target in, PC and status out.
interface pc_fetch_unit_if #(
  parameter int D    = 12,
  parameter int OFFW = 8
);
  logic            Start;
  logic            Stall;
  logic            Halt;
  logic            BranchEn;
  logic            Taken;
  logic [D-1:0]    Target;
  logic            RelEn;
  logic [OFFW-1:0] Offset;
  logic            Call;
  logic            Ret;
  logic [D-1:0]    PC;
  logic            Running;
  logic            Done;
  logic [15:0]     InstrCount;
  logic            StackErr;

  modport master (
    output Start, Stall, Halt, BranchEn, Taken, Target, RelEn, Offset, Call, Ret,
    input  PC, Running, Done, InstrCount, StackErr
  );

  modport slave (
    input  Start, Stall, Halt, BranchEn, Taken, Target, RelEn, Offset, Call, Ret,
    output PC, Running, Done, InstrCount, StackErr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch sequencer with IDLE-RUN-DONE control.
// Define CALL_STACK_EN to build the LIFO return-address stack for Call/Ret.
module pc_fetch_unit #(
  parameter int D           = 12,
  parameter int OFFW        = 8,
  parameter int STACK_DEPTH = 4
) (
  input logic           Clk,
  input logic           Reset,
  pc_fetch_unit_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic [15:0] count_q, count_d;
  logic        err_q, err_d;

  logic [D-1:0] pc_inc;
  logic [D-1:0] pc_rel;

  assign pc_inc = pc_q + D'(1);
  assign pc_rel = pc_q + {{(D-OFFW){bus.Offset[OFFW-1]}}, bus.Offset};

`ifdef CALL_STACK_EN
  localparam int SPW  = $clog2(STACK_DEPTH + 1);
  localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [D-1:0]    stack_q [STACK_DEPTH];
  logic [D-1:0]    stack_d [STACK_DEPTH];
  logic [SPW-1:0]  sp_q, sp_d;
  logic            stack_empty, stack_full;
  logic [IDXW-1:0] top_idx, push_idx;

  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
  assign top_idx     = IDXW'(sp_q - SPW'(1));
  assign push_idx    = IDXW'(sp_q);
`else
  logic unused_ret;
  assign unused_ret = bus.Ret;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    running_d = running_q;
    done_d    = done_q;
    count_d   = count_q;
    err_d     = err_q;
`ifdef CALL_STACK_EN
    sp_d      = sp_q;
    stack_d   = stack_q;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (!bus.Stall) begin
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (bus.Halt) begin
            state_d   = ST_DONE;
            running_d = 1'b0;
            done_d    = 1'b1;
          end
`ifdef CALL_STACK_EN
          else if (bus.Ret) begin
            // Underflow still advances so a stray return does not wedge the program.
            if (stack_empty) begin
              pc_d  = pc_inc;
              err_d = 1'b1;
            end else begin
              pc_d = stack_q[top_idx];
              sp_d = sp_q - SPW'(1);
            end
          end else if (bus.Call) begin
            pc_d = bus.Target;
            if (stack_full) begin
              err_d = 1'b1;
            end else begin
              stack_d[push_idx] = pc_inc;
              sp_d              = sp_q + SPW'(1);
            end
          end
`else
          else if (bus.Call) pc_d = bus.Target;
`endif
          else if (bus.BranchEn && bus.Taken) pc_d = bus.Target;
          else if (bus.RelEn) pc_d = pc_rel;
          else pc_d = pc_inc;
        end
      end
      default: begin
        // IDLE and DONE only react to Start.
        if (bus.Start) begin
          state_d   = ST_RUN;
          pc_d      = '0;
          running_d = 1'b1;
          done_d    = 1'b0;
          count_d   = '0;
          err_d     = 1'b0;
`ifdef CALL_STACK_EN
          sp_d      = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
`ifdef CALL_STACK_EN
      sp_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= running_d;
      done_q    <= done_d;
      count_q   <= count_d;
      err_q     <= err_d;
`ifdef CALL_STACK_EN
      sp_q      <= sp_d;
`endif
    end
  end

`ifdef CALL_STACK_EN
  for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) stack_q[gi] <= '0;
      else       stack_q[gi] <= stack_d[gi];
    end
  end
`endif

  assign bus.PC         = pc_q;
  assign bus.Running    = running_q;
  assign bus.Done       = done_q;
  assign bus.InstrCount = count_q;
  assign bus.StackErr   = err_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: behavioural model checked every cycle plus literal pins.
module tb_pc_fetch_unit;
  localparam int D     = 12;
  localparam int OFFW  = 8;
  localparam int DEPTH = 4;
  localparam int MODN  = 1 << D;
`ifdef CALL_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;

  pc_fetch_unit_if #(.D(D), .OFFW(OFFW)) bus ();

  pc_fetch_unit #(.D(D), .OFFW(OFFW), .STACK_DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  mstate_t m_state;
  int      m_pc;
  int      m_cnt;
  bit      m_err;
  int      m_stack[$];

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = 0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_stack.delete();
  endtask

  // Applies the architectural rules to the inputs present at this clock edge.
  task automatic model_step();
    int off;
    if (Reset) begin
      model_reset();
      return;
    end
    if (m_state != M_RUN) begin
      if (bus.Start) begin
        m_state = M_RUN;
        m_pc    = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
        m_stack.delete();
      end
      return;
    end
    if (bus.Stall) return;
    if (m_cnt < 65535) m_cnt = m_cnt + 1;
    if (bus.Halt) begin
      m_state = M_DONE;
    end else if (STACK_EN && bus.Ret) begin
      if (m_stack.size() == 0) begin
        m_pc  = (m_pc + 1) % MODN;
        m_err = 1'b1;
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else if (bus.Call) begin
      if (STACK_EN) begin
        if (m_stack.size() == DEPTH) m_err = 1'b1;
        else m_stack.push_back((m_pc + 1) % MODN);
      end
      m_pc = int'(bus.Target);
    end else if (bus.BranchEn && bus.Taken) begin
      m_pc = int'(bus.Target);
    end else if (bus.RelEn) begin
      off = int'(bus.Offset);
      if (off >= (1 << (OFFW - 1))) off = off - (1 << OFFW);
      m_pc = ((m_pc + off) % MODN + MODN) % MODN;
    end else begin
      m_pc = (m_pc + 1) % MODN;
    end
  endtask

  task automatic check_outputs(input string tag);
    int exp_run, exp_done;
    exp_run  = (m_state == M_RUN)  ? 1 : 0;
    exp_done = (m_state == M_DONE) ? 1 : 0;
    tests++;
    if (int'(bus.PC) != m_pc || int'(bus.Running) != exp_run || int'(bus.Done) != exp_done ||
        int'(bus.InstrCount) != m_cnt || bus.StackErr != m_err) begin
      fails++;
      $display("FAIL %s cyc=%0d: got PC=%0d Running=%0b Done=%0b InstrCount=%0d StackErr=%0b, want PC=%0d Running=%0d Done=%0d InstrCount=%0d StackErr=%0b",
               tag, cyc, bus.PC, bus.Running, bus.Done, bus.InstrCount, bus.StackErr,
               m_pc, exp_run, exp_done, m_cnt, m_err);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    cyc++;
    check_outputs("model");
    $display("[TB] cyc=%0d PC=%0d Running=%0b Done=%0b InstrCount=%0d StackErr=%0b",
             cyc, bus.PC, bus.Running, bus.Done, bus.InstrCount, bus.StackErr);
  endtask

  task automatic clr();
    bus.Start    = 1'b0;
    bus.Stall    = 1'b0;
    bus.Halt     = 1'b0;
    bus.BranchEn = 1'b0;
    bus.Taken    = 1'b0;
    bus.Target   = '0;
    bus.RelEn    = 1'b0;
    bus.Offset   = '0;
    bus.Call     = 1'b0;
    bus.Ret      = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    clr();
    model_reset();
    #2;
    check_outputs("reset");
    check_lit("reset_pc", int'(bus.PC), 0);
    check_lit("reset_running", int'(bus.Running), 0);
    #10;
    Reset = 1'b0;

    // Strobes in IDLE do nothing
    bus.BranchEn = 1'b1; bus.Taken = 1'b1; bus.Target = 12'd77; bus.RelEn = 1'b1; bus.Offset = 8'd5;
    tick(); tick();
    check_lit("idle_pc", int'(bus.PC), 0);
    clr();

    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check_lit("start_running", int'(bus.Running), 1);
    check_lit("start_pc", int'(bus.PC), 0);
    for (int i = 0; i < 5; i++) tick();
    check_lit("free_pc", int'(bus.PC), 5);
    check_lit("free_count", int'(bus.InstrCount), 5);

    bus.RelEn = 1'b1; bus.Offset = 8'hFE;
    tick();
    clr();
    check_lit("rel_back_pc", int'(bus.PC), 3);

    bus.BranchEn = 1'b1; bus.Taken = 1'b1; bus.Target = 12'd142;
    tick();
    check_lit("branch_taken_pc", int'(bus.PC), 142);
    bus.Taken = 1'b0;
    tick();
    check_lit("branch_not_taken_pc", int'(bus.PC), 143);
    clr();

    bus.BranchEn = 1'b1; bus.Taken = 1'b1; bus.Target = 12'd4095;
    tick();
    clr();
    tick();
    check_lit("wrap_pc", int'(bus.PC), 0);
    tick(); tick();
    bus.RelEn = 1'b1; bus.Offset = 8'hFB;
    tick();
    clr();
    check_lit("rel_wrap_pc", int'(bus.PC), 4093);

    // Start while running is ignored
    bus.BranchEn = 1'b1; bus.Taken = 1'b1; bus.Target = 12'd20; bus.Start = 1'b1;
    tick();
    clr();
    bus.Stall = 1'b1; bus.Halt = 1'b1;
    tick();
    check_lit("stall_halt_pc", int'(bus.PC), 20);
    check_lit("stall_halt_running", int'(bus.Running), 1);
    bus.Stall = 1'b0; bus.BranchEn = 1'b1; bus.Taken = 1'b1; bus.Target = 12'd99;
    tick();
    clr();
    check_lit("halt_done", int'(bus.Done), 1);
    check_lit("halt_running", int'(bus.Running), 0);
    check_lit("halt_pc", int'(bus.PC), 20);

    bus.BranchEn = 1'b1; bus.Taken = 1'b1; bus.Target = 12'd5; bus.RelEn = 1'b1;
    tick(); tick();
    clr();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check_lit("restart_pc", int'(bus.PC), 0);
    check_lit("restart_count", int'(bus.InstrCount), 0);
    check_lit("restart_done", int'(bus.Done), 0);

    bus.BranchEn = 1'b1; bus.Taken = 1'b1; bus.Target = 12'd200;
    tick();
    check_lit("pre_reset_pc", int'(bus.PC), 200);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check_outputs("async_reset");
    check_lit("async_reset_pc", int'(bus.PC), 0);
    check_lit("async_reset_running", int'(bus.Running), 0);
    tick();
    Reset = 1'b0;
    bus.Target = 12'd300; bus.RelEn = 1'b1; bus.Offset = 8'd9; bus.Halt = 1'b1;
    tick(); tick();
    check_lit("post_reset_idle_pc", int'(bus.PC), 0);
    check_lit("post_reset_idle_running", int'(bus.Running), 0);
    clr();
    bus.Start = 1'b1;
    tick();
    clr();

`ifdef CALL_STACK_EN
    bus.BranchEn = 1'b1; bus.Taken = 1'b1; bus.Target = 12'd10;
    tick();
    clr();
    bus.Call = 1'b1; bus.Target = 12'd81;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_lit("call_pc", int'(bus.PC), 81);
      check_lit("call_err", int'(bus.StackErr), (i == 5) ? 1 : 0);
    end
    clr();
    bus.Ret = 1'b1;
    tick(); check_lit("ret1_pc", int'(bus.PC), 82);
    tick(); check_lit("ret2_pc", int'(bus.PC), 82);
    tick(); check_lit("ret3_pc", int'(bus.PC), 82);
    tick(); check_lit("ret4_pc", int'(bus.PC), 11);
    tick(); check_lit("ret_underflow_pc", int'(bus.PC), 12);
    check_lit("ret_underflow_err", int'(bus.StackErr), 1);
    clr();
    bus.Halt = 1'b1;
    tick();
    clr();
    bus.Start = 1'b1;
    tick();
    clr();
    check_lit("err_cleared", int'(bus.StackErr), 0);
`else
    bus.Call = 1'b1; bus.Target = 12'd81;
    tick();
    clr();
    check_lit("call_as_branch_pc", int'(bus.PC), 81);
    bus.Ret = 1'b1;
    tick();
    clr();
    check_lit("ret_as_nop_pc", int'(bus.PC), 82);
    check_lit("stackerr_tied", int'(bus.StackErr), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program counter and fetch sequencer for the custom processor. It holds the instruction address, steps it each cycle, and applies taken branches using the absolute target from the branch-target lookup table, short relative jumps, and halts. It sits between the decoder/branch-target table and instruction memory: decoder strobes and the LUT target come in, and the registered `PC` goes out to instruction ROM.

## Interface
Parameters:
- `D`, 12: PC width, in bits.
- `OFFW`, 8: width of the signed relative-jump offset.
- `STACK_DEPTH`, 4: number of return-stack entries (used only with `CALL_STACK_EN`).

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  one-cycle pulse that starts or restarts execution.
- `Stall`  in  1  hold all state this cycle (memory or decoder not ready).
- `Halt`  in  1  current instruction is the program-done instruction.
- `BranchEn`  in  1  current instruction is a conditional absolute branch.
- `Taken`  in  1  branch condition is true; qualified by `BranchEn`.
- `Target`  in  D  absolute target from the branch-target LUT.
- `RelEn`  in  1  current instruction is an unconditional relative jump.
- `Offset`  in  OFFW  two's-complement offset for `RelEn`.
- `Call`  in  1  call to `Target` (stack feature).
- `Ret`  in  1  return (stack feature).
- `PC`  out  D  current instruction address (registered).
- `Running`  out  1  high in the RUN state.
- `Done`  out  1  high in the DONE state.
- `InstrCount`  out  16  number of instructions retired since the last start.
- `StackErr`  out  1  sticky stack overflow/underflow flag.

## Operation
- Reset values: state IDLE, `PC`=0, `Running`=0, `Done`=0, `InstrCount`=0, stack pointer=0, `StackErr`=0.
- IDLE:
  - `PC` holds at 0.
  - `Start` moves to RUN.
- RUN: the control inputs describe the instruction at the current `PC`. The next `PC` is chosen by fixed priority:
  1. `Stall`: hold everything.
  2. `Halt`: go to DONE; `PC` holds.
  3. `Ret`.
  4. `Call`.
  5. `BranchEn & Taken`: `PC`<=`Target`.
  6. `RelEn`: `PC`<=(`PC` + sign-extended `Offset`) mod 2^D.
  7. Otherwise: `PC`<=(`PC`+1) mod 2^D.
- A not-taken branch (`BranchEn` with `Taken`=0) falls through to `PC`+1.
- Wrap-around: 2^D−1 plus 1 gives 0. A relative jump of −5 from `PC`=2 gives 2^D−3. There is no error in either case.
- `InstrCount` increments on every non-stalled RUN cycle, including the `Halt` cycle. It saturates at 0xFFFF.
- DONE:
  - `PC` and `InstrCount` hold.
  - `Start` sets `PC`<=0, `InstrCount`<=0, clears the stack and `StackErr`, and moves to RUN.
- `Start` is ignored in RUN.
- All strobes are ignored outside RUN.
- `Reset` asserted mid-program returns every register to its reset value immediately; no edge is required.

## Timing
- Every output is a register output; there is no combinational path from input to output.
- Branch, jump and return latency is one cycle: the new `PC` is visible in the cycle after the strobe.
- `Start` in IDLE or DONE: `Running`=1 on the next cycle, with `PC`=0. Address 0 is fetched in that first RUN cycle.
- `Halt`: `Done`=1 and `Running`=0 on the next cycle.
- `Stall` takes effect in the same cycle and overrides every other strobe, including `Halt`.
- `Target` is sampled only in the cycle in which it is used. The LUT path must settle within one cycle.

## Configuration
The `CALL_STACK_EN` macro controls the return-address stack.

Defined:
- The return stack is `STACK_DEPTH` entries of D bits, LIFO.
- `Call` pushes (`PC`+1) mod 2^D and sets `PC`<=`Target`.
- `Call` when the stack is full: no push, the jump still happens, `StackErr` is set.
- `Ret` pops, and `PC`<=popped value.
- `Ret` when the stack is empty: `PC`<=`PC`+1, `StackErr` is set.
- `StackErr` stays set until `Reset` or `Start`.

Undefined:
- No stack storage is built.
- `Call` behaves exactly like a taken branch to `Target`.
- `Ret` is treated as no strobe (`PC`+1).
- `StackErr` is tied to 0.

## Test plan
- Reset, then `Start` pulse, then 5 free-running cycles -> `PC` sequence 0,1,2,3,4,5; `InstrCount`=5; `Running`=1.
- `BranchEn`=1 with `Taken`=1 and `Target`=142 at `PC`=3, then `Taken`=0 at `PC`=142 -> `PC`=142, then 143.
- `PC` at 4095 with no strobe -> `PC`=0. `RelEn` with `Offset`=−5 (0xFB) at `PC`=2 -> `PC`=4093.
- `Halt` and `BranchEn`/`Taken` together at `PC`=20 -> `Done`=1, `PC`=20 held. `Stall` and `Halt` together -> no change. `Start` from DONE -> `PC`=0, `InstrCount`=0.
- Asynchronous `Reset` pulse between clock edges at `PC`=200 -> `PC`=0 and IDLE immediately. Strobes stay ignored until `Start`.
- With `CALL_STACK_EN`:
  - 5 calls to `Target`=81 from `PC`=10, 81, 81, 81, 81 -> fifth call gives `StackErr`=1, `PC`=81.
  - 4 returns -> `PC` = 82, 82, 82, 11.
  - A 5th return -> `PC`+1.
